// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus of the shared-multiplier arbiter: request/operand inputs,
// grant, and the routed product response.
interface mul_share_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_en;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            busy;

  modport master (
    output req_en, req, req_a, req_b,
    input  gnt, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_en, req, req_a, req_b,
    output gnt, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin time-sharing of one free-running pipelined 16x16 multiplier among
// N requesters; a tag pipeline matched to LAT routes each product back.
module mul_share_arbiter #(
  parameter int N   = 4,
  parameter int LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_share_arbiter_if.slave  bus,
  output logic [15:0]         mul_a,
  output logic [15:0]         mul_b,
  input  logic [31:0]         mul_result
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int D  = LAT + 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [N-1:0]  elig_s;
  logic [N-1:0]  gnt_s;
  logic [PW-1:0] gnt_id_s;
  logic          gnt_any_s;
  logic [PW:0]   idx_s;
  logic [D-1:0]  tag_valid_r;
  logic [PW-1:0] tag_id_r [D];
  logic [15:0]   mul_a_r;
  logic [15:0]   mul_b_r;
  logic [N-1:0]  rsp_valid_r;
  logic [31:0]   rsp_data_r;

  // Pick the first eligible requester walking from ptr upward, wrapping mod N.
  always_comb begin
    elig_s    = bus.req & bus.req_en;
    gnt_s     = '0;
    gnt_id_s  = '0;
    gnt_any_s = 1'b0;
    idx_s     = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr_r} + (PW+1)'(k);
      if (idx_s >= (PW+1)'(N)) begin
        idx_s = idx_s - (PW+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_any_s && elig_s[idx_s[PW-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_id_s  = idx_s[PW-1:0];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    // Grant is suppressed while reset is held so no requester sees a phantom gnt.
    if (gnt_any_s && rst_n) begin
      gnt_s[gnt_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
    if (gnt_id_s == PW'(N-1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_id_s + PW'(1);
    end
  end

  // Operand capture, pointer advance, tag pipeline and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      mul_a_r     <= 16'h0000;
      mul_b_r     <= 16'h0000;
      tag_valid_r <= '0;
      for (int k = 0; k < D; k++) begin
        tag_id_r[k] <= '0;
      end
      rsp_valid_r <= '0;
      rsp_data_r  <= 32'h0000_0000;
    end else begin
      if (gnt_any_s) begin
        mul_a_r <= bus.req_a[{gnt_id_s, 4'b0000} +: 16];
        mul_b_r <= bus.req_b[{gnt_id_s, 4'b0000} +: 16];
        ptr_r   <= ptr_nxt_s;
      end else begin
        mul_a_r <= mul_a_r;
        mul_b_r <= mul_b_r;
        ptr_r   <= ptr_r;
      end
      // The multiplier never stalls, so tags advance every cycle.
      tag_valid_r <= {tag_valid_r[D-2:0], gnt_any_s};
      tag_id_r[0] <= gnt_id_s;
      for (int k = 1; k < D; k++) begin
        tag_id_r[k] <= tag_id_r[k-1];
      end
      if (tag_valid_r[D-1]) begin
        rsp_valid_r <= N'(1) << tag_id_r[D-1];
        rsp_data_r  <= mul_result;
      end else begin
        rsp_valid_r <= '0;
        rsp_data_r  <= rsp_data_r;
      end
    end
  end

  assign bus.gnt       = gnt_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = |tag_valid_r;
  assign mul_a         = mul_a_r;
  assign mul_b         = mul_b_r;
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that time-shares one free-running pipelined 16x16 multiplier (the vedic 16x16 array) among N requesters in the matrix-multiplier datapath. Each cycle it grants at most one pending request and registers that requester's operands onto the multiplier inputs. A tag pipeline matched to the multiplier latency routes each 32-bit product back to its originating requester with a one-cycle valid pulse. Processing elements use it so that several dot-product lanes share one multiplier instance.

## Interface
- N, default 4: number of requesters (2..8).
- LAT, default 4: multiplier latency in cycles, from operands on mul_a/mul_b to the matching product on mul_result (1..8).
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_en  in  N: per-requester enable mask; a 0 bit makes that requester ineligible for grant.
- req  in  N: request bits; requester i holds req[i] high until it sees gnt[i].
- req_a  in  16*N: operand A, packed; slice i is [16*i+15:16*i].
- req_b  in  16*N: operand B, packed the same way.
- gnt  out  N: one-hot or zero; combinational in the request cycle.
- mul_a  out  16: registered operand A to the multiplier.
- mul_b  out  16: registered operand B to the multiplier.
- mul_result  in  32: product from the multiplier.
- rsp_valid  out  N: one-hot or zero; registered response strobe.
- rsp_data  out  32: product for the requester flagged by rsp_valid.
- busy  out  1: high while any issued product is still in flight.

## Operation
- Eligible set: req & req_en.
- Round-robin pointer ptr (log2 N bits) names the highest-priority requester. Priority order is ptr, ptr+1, ..., wrapping mod N.
- gnt goes high for the first eligible requester in priority order. If none is eligible, gnt = 0.
- On a grant to requester g:
  - mul_a <= req_a slice g; mul_b <= req_b slice g.
  - ptr <= (g+1) mod N.
  - A tag {valid=1, id=g} enters stage 0 of the tag pipeline.
- With no grant: mul_a and mul_b hold their values, ptr holds, and a tag with valid=0 enters the pipeline.
- Tag pipeline depth is LAT+1 stages. Stage k+1 takes stage k every cycle, unconditionally, because the multiplier never stalls.
- When the last stage holds valid=1 and id=g:
  - rsp_valid <= one-hot(g) on the next edge.
  - rsp_data <= mul_result, sampled in the same cycle the last stage is read.
- With no valid tag in the last stage, rsp_valid <= 0 and rsp_data holds.
- busy = OR of the valid bits in all tag stages.
- A requester may drop req without being granted. No grant is then issued for it.
- A requester may re-request in the cycle after its gnt. Round-robin means it waits behind the other eligible requesters.
- Clearing a req_en bit does not affect products already in flight for that requester; they are still delivered.
- Products are unsigned. Width is 16x16 to 32, passed through with no truncation.

## Timing
- Reset values: gnt=0 (no eligible request while in reset), mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0, busy=0, ptr=0, all tag valid bits 0.
- Cycle numbering for a grant in cycle t (gnt[g] high during t):
  - Operands appear on mul_a/mul_b in cycle t+1.
  - mul_result for those operands is valid in cycle t+1+LAT.
  - rsp_valid[g] is high, with rsp_data valid, for exactly cycle t+2+LAT.
- End-to-end latency from gnt to rsp_valid is LAT+2 cycles.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses, in the same order they were granted.
- If reset is asserted mid-operation, all in-flight tags are discarded and no response is ever produced for them. After rst_n deasserts, ptr=0.

## Test plan
- Single request, with N=4 and LAT=4: req[2]=1, a=0x0003, b=0x0005 in cycle 10.
  - gnt=0100 in cycle 10.
  - rsp_valid=0100 and rsp_data=0x0000000F in cycle 16; busy high during cycles 11-15.
- Round-robin fairness: req=1111 held continuously with ptr=0.
  - gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Responses arrive in that same order, each 6 cycles after its grant.
- Max operands: a=0xFFFF, b=0xFFFF on requester 1 -> rsp_data=0xFFFE0001 with rsp_valid=0010.
- Mask and wrap:
  - req=1011 with req_en=0011 and ptr=1: grants go 0010 then 0001; requester 3 is never granted.
  - Then set req_en=1111: requester 3 is granted next.
- Reset mid-flight: grant requester 0, then pull rst_n low 2 cycles later.
  - All outputs are 0 immediately.
  - No rsp_valid pulse appears afterwards; first grant after release goes to the lowest eligible index.
- Idle gaps: single requests in cycles 5 and 7 -> responses in cycles 11 and 13 only. rsp_data holds 11's value in cycle 12.
